// File: rtl/sipo_deser_ctrl.sv
// Frame controller for a serial-in/parallel-out path: counts qualified bits after start,
// then holds the assembled word on a valid/ready port. Optional parity: SIPO_PARITY_EN.
module sipo_deser_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din_valid,
  input  logic             din,
  output logic             shift_en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  // The parity bit occupies count position WIDTH and never enters the data word.
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             overrun_reg;
`ifdef SIPO_PARITY_EN
  logic             parity_err_reg;
`endif

  // LSB-first: each new bit enters at the top and the word drifts toward bit 0.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sreg_next[gi] = sreg_reg[gi+1];
    end
  endgenerate
  assign sreg_next[WIDTH-1] = din;

  assign shift_en  = (state_reg == SHIFT) && din_valid;
  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign overrun   = overrun_reg;
`ifdef SIPO_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      sreg_reg       <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SHIFT;
            count_reg <= '0;
            sreg_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
        SHIFT: begin
          if (din_valid) begin
            count_reg <= count_reg + CW'(1);
`ifdef SIPO_PARITY_EN
            if (count_reg < CW'(WIDTH)) begin
              sreg_reg <= sreg_next;
            end
            if (count_reg == LAST_CNT) begin
              state_reg      <= HOLD;
              busy_reg       <= 1'b0;
              out_valid_reg  <= 1'b1;
              out_data_reg   <= sreg_reg;
              parity_err_reg <= (^sreg_reg) ^ din;
            end
`else
            sreg_reg <= sreg_next;
            if (count_reg == LAST_CNT) begin
              state_reg     <= HOLD;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b1;
              out_data_reg  <= sreg_next;
            end
`endif
          end
        end
        HOLD: begin
          if (din_valid) begin
            overrun_reg <= 1'b1;
          end
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deser_ctrl.sv
// Self-checking bench for sipo_deser_ctrl (WIDTH=4): directed scenarios plus randomized
// frames checked against a bit-packing reference model.
module tb_sipo_deser_ctrl;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME_BITS = W + 1;
`else
  localparam int FRAME_BITS = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         din_valid = 1'b0;
  logic         din = 1'b0;
  logic         out_ready = 1'b0;
  logic         shift_en;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         overrun;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int shift_pulses = 0;
  int handshakes = 0;
  logic [W-1:0] word_sink;

  sipo_deser_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .shift_en  (shift_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (shift_en) shift_pulses <= shift_pulses + 1;
    if (out_valid && out_ready) handshakes <= handshakes + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    din_valid = 1'b1;
    din = b;
    step();
    din_valid = 1'b0;
    din = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Appends the correct even-parity bit when the frame carries one.
  task automatic finish_frame(input logic [W-1:0] w);
`ifdef SIPO_PARITY_EN
    send_bit(^w);
`else
    word_sink = w;
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({out_valid, busy, overrun, shift_en} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid, busy, overrun, shift_en});
    end
    vectors++;
    if (out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    din_valid = 1'b1;
    din = 1'b1;
    #1;
    vectors++;
    if (shift_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_shift_en: got %b expected 0", shift_en);
    end
    step();
    din_valid = 1'b0;
    vectors++;
    if ({busy, overrun, out_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_din_ignored: got %b expected 000", {busy, overrun, out_valid});
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    din_valid = 1'b1;
    din = 1'b0;
    #1;
    vectors++;
    if (shift_en !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_shift_en: got %b expected 1", shift_en);
    end
    step();
    din_valid = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    send_bit(1'b1);
    finish_frame(4'hE);
    vectors++;
    if ({out_valid, busy, out_data} !== {2'b10, 4'hE}) begin
      miscompares++;
      $display("FAIL basic_word: got valid=%b busy=%b data=%h expected valid=1 busy=0 data=e",
               out_valid, busy, out_data);
    end
    handshake();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_release: got %b expected 0", out_valid);
    end
    $display("test_basic word=%h", out_data);
  endtask

  task automatic test_gapped();
    int p0;
    p0 = shift_pulses;
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      din = 1'($urandom_range(0, 1));
      step();
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gapped_wait: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    finish_frame(4'hE);
    vectors++;
    if (shift_pulses - p0 !== FRAME_BITS) begin
      miscompares++;
      $display("FAIL gapped_pulses: got %0d expected %0d", shift_pulses - p0, FRAME_BITS);
    end
    vectors++;
    if (out_data !== 4'hE || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL gapped_word: got %h/%b expected e/1", out_data, out_valid);
    end
    handshake();
    $display("test_gapped word=%h pulses=%0d", out_data, shift_pulses - p0);
  endtask

  task automatic test_backpressure();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    finish_frame(4'h5);
    for (int i = 0; i < 10; i++) begin
      din_valid = (i == 5);
      din = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 4'h5) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %b/%h expected 1/5", i, out_valid, out_data);
      end
    end
    din_valid = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_overrun: got %b expected 1", overrun);
    end
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_sticky: got valid=%b overrun=%b expected 0/1", out_valid, overrun);
    end
    do_reset();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_overrun_clr: got %b expected 0", overrun);
    end
    $display("test_backpressure word=5 overrun cleared by rst");
  endtask

  task automatic test_reset_midframe();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, out_valid, out_data} !== {2'b00, 4'h0}) begin
      miscompares++;
      $display("FAIL midrst_state: got busy=%b valid=%b data=%h expected 0/0/0", busy, out_valid, out_data);
    end
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    finish_frame(4'h3);
    vectors++;
    if (out_data !== 4'h3 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_word: got %h/%b expected 3/1", out_data, out_valid);
    end
    handshake();
    $display("test_reset_midframe word=%h", out_data);
  endtask

  task automatic test_ignored_start();
    int h0;
    h0 = handshakes;
    pulse_start();
    send_bit(1'b1);
    start = 1'b1;
    send_bit(1'b0);
    start = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    finish_frame(4'hD);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'hD) begin
      miscompares++;
      $display("FAIL ign_word: got %b/%h expected 1/d", out_valid, out_data);
    end
    pulse_start();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'hD) begin
      miscompares++;
      $display("FAIL ign_hold_start: got %b/%h expected 1/d", out_valid, out_data);
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    step();
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL ign_same_cycle: got busy=%b valid=%b expected 0/0", busy, out_valid);
    end
    vectors++;
    if (handshakes - h0 !== 1) begin
      miscompares++;
      $display("FAIL ign_word_count: got %0d expected 1", handshakes - h0);
    end
    $display("test_ignored_start words=%0d", handshakes - h0);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(k == 0);
      vectors++;
      if (out_data !== 4'hE || parity_err !== (k == 1)) begin
        miscompares++;
        $display("FAIL parity[%0d]: got data=%h err=%b expected e/%b", k, out_data, parity_err, k == 1);
      end
      handshake();
      vectors++;
      if (parity_err !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_clr[%0d]: got %b expected 0", k, parity_err);
      end
      $display("test_parity case %0d", k);
    end
  endtask
`endif

  task automatic test_random();
    logic         bits [W];
    logic [W-1:0] exp_word;
    logic         exp_ovr;
    do_reset();
    exp_ovr = 1'b0;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        din_valid = 1'($urandom_range(0, 1));
        step();
      end
      din_valid = 1'b0;
      vectors++;
      if (busy !== 1'b0 || overrun !== exp_ovr) begin
        miscompares++;
        $display("FAIL rnd_idle[%0d]: got busy=%b ovr=%b expected 0/%b", f, busy, overrun, exp_ovr);
      end
      pulse_start();
      exp_word = '0;
      for (int b = 0; b < W; b++) begin
        bits[b] = 1'($urandom_range(0, 1));
        exp_word = exp_word | (W'(bits[b]) << b);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        send_bit(bits[b]);
      end
      finish_frame(exp_word);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_word) begin
        miscompares++;
        $display("FAIL rnd_word[%0d]: got %b/%h expected 1/%h", f, out_valid, out_data, exp_word);
      end
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        din_valid = ($urandom_range(0, 3) == 0);
        exp_ovr = exp_ovr | din_valid;
        step();
      end
      din_valid = ($urandom_range(0, 3) == 0);
      exp_ovr = exp_ovr | din_valid;
      handshake();
      din_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || overrun !== exp_ovr) begin
        miscompares++;
        $display("FAIL rnd_done[%0d]: got valid=%b ovr=%b expected 0/%b", f, out_valid, overrun, exp_ovr);
      end
      $display("frame %0d word=%h overrun=%b", f, exp_word, exp_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_reset_midframe();
    test_ignored_start();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
